// File: rtl/rv32i_types.sv
// rv32i_types
//   Shared RV32I type definitions used across the pipeline.
//   - load_funct3_t  : funct3 encodings of the load instructions
//   - retire_state_t : state of the leapfrog retire unit (leap_retire)
// No ports; this file is a package only.
package rv32i_types;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WB   = 2'b10
    } retire_state_t;

endpackage

// File: rtl/load_align.sv
// load_align
//   Combinational load data aligner shared by the MA-stage load path and the
//   leapfrog retire unit. Picks the addressed byte/half out of the fetched
//   word and sign- or zero-extends it according to the load funct3.
// Ports:
//   rdata   in  32  word returned by the data cache
//   offset  in   2  byte offset within the word (addr[1:0])
//   funct3  in   3  load_funct3_t of the load
//   aligned out 32  register-file ready load result
module load_align
    import rv32i_types::*;
(
    input  logic [31:0]  rdata,
    input  logic [1:0]   offset,
    input  load_funct3_t funct3,
    output logic [31:0]  aligned
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // Select the addressed byte and half-word. Halves only look at offset[1];
    // misaligned halves and words are not supported, so offset[0] is ignored
    // for them.
    always_comb begin
        byteSel = rdata[7:0];
        case (offset)
            2'd0: byteSel = rdata[7:0];
            2'd1: byteSel = rdata[15:8];
            2'd2: byteSel = rdata[23:16];
            2'd3: byteSel = rdata[31:24];
            default: byteSel = rdata[7:0];
        endcase
        halfSel = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extend the selected lane according to the load type.
    always_comb begin
        aligned = rdata;
        case (funct3)
            lb:      aligned = {{24{byteSel[7]}}, byteSel};
            lbu:     aligned = {24'd0, byteSel};
            lh:      aligned = {{16{halfSel[15]}}, halfSel};
            lhu:     aligned = {16'd0, halfSel};
            lw:      aligned = rdata;
            default: aligned = rdata;
        endcase
    end

endmodule

// File: rtl/leap_retire.sv
// leap_retire
//   Retire unit for a missing load/store that younger instructions have
//   leapfrogged. Takes ownership of the MA-stage memory op, holds the dcache
//   request until the response, aligns load data and writes it into the
//   register file on the shared port whenever pipeline writeback leaves the
//   port idle. Exports the pending destination to the leapfrog hazard check.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   capture_valid/ready              hand-off of the stalled MA memory op
//   capture_is_load/funct3/rd        op kind, load type, load destination
//   capture_addr/wdata/wmask         byte address, store data and byte enables
//   dmem_read/write/address          dcache request (word-aligned address)
//   dmem_wdata/byte_enable           store data and mask (4'hF on reads)
//   dmem_rdata/resp                  dcache response
//   wb_pipe_valid/rd                 pipeline WB use of the register file port
//   rf_wr/rf_rd/rf_data              retire write on the shared port
//   pending_valid/pending_rd         held op and its destination (0 for stores)
module leap_retire
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,

    input  logic        capture_valid,
    output logic        capture_ready,
    input  logic        capture_is_load,
    input  logic [2:0]  capture_funct3,
    input  logic [4:0]  capture_rd,
    input  logic [31:0] capture_addr,
    input  logic [31:0] capture_wdata,
    input  logic [3:0]  capture_wmask,

    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_byte_enable,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,

    input  logic        wb_pipe_valid,
    input  logic [4:0]  wb_pipe_rd,

    output logic        rf_wr,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_data,

    output logic        pending_valid,
    output logic [4:0]  pending_rd
);

    retire_state_t state_q;
    logic          isLoad_q;
    load_funct3_t  funct3_q;
    logic [4:0]    rd_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wmask_q;
    logic          kill_q;
    logic [31:0]   data_q;
    logic          dmemRead_q;
    logic          dmemWrite_q;
    logic          pendingValid_q;
    logic [4:0]    pendingRd_q;

    logic [31:0]   alignedData;
    logic          wawHit;
    logic          rfWrFire;

    // Same aligner as the MA-stage load path, fed from the held address and
    // funct3 so the response data can be registered on the resp edge.
    load_align u_load_align (
        .rdata   (dmem_rdata),
        .offset  (addr_q[1:0]),
        .funct3  (funct3_q),
        .aligned (alignedData)
    );

    // A younger pipeline write to the held rd makes our result stale. Stores
    // hold rd = 0, so they can never be killed.
    assign wawHit   = wb_pipe_valid && (wb_pipe_rd == rd_q) && (rd_q != 5'd0);

    // The pipeline always owns the port when it wants it; we only fill gaps.
    assign rfWrFire = (state_q == WB) && !wb_pipe_valid && !kill_q && (rd_q != 5'd0);

    // The whole retire FSM: capture in IDLE, hold the dcache request in REQ,
    // wait for a free register-file port in WB. Strobes and pending info are
    // registered here so nothing on capture_* reaches dmem_* combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            isLoad_q       <= 1'b0;
            funct3_q       <= lb;
            rd_q           <= 5'd0;
            addr_q         <= 32'd0;
            wdata_q        <= 32'd0;
            wmask_q        <= 4'd0;
            kill_q         <= 1'b0;
            data_q         <= 32'd0;
            dmemRead_q     <= 1'b0;
            dmemWrite_q    <= 1'b0;
            pendingValid_q <= 1'b0;
            pendingRd_q    <= 5'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (capture_valid) begin
                        isLoad_q       <= capture_is_load;
                        funct3_q       <= load_funct3_t'(capture_funct3);
                        rd_q           <= capture_is_load ? capture_rd : 5'd0;
                        addr_q         <= capture_addr;
                        wdata_q        <= capture_wdata;
                        wmask_q        <= capture_wmask;
                        kill_q         <= 1'b0;
                        dmemRead_q     <= capture_is_load;
                        dmemWrite_q    <= !capture_is_load;
                        pendingValid_q <= 1'b1;
                        pendingRd_q    <= capture_is_load ? capture_rd : 5'd0;
                        state_q        <= REQ;
                    end
                end
                REQ: begin
                    if (wawHit) begin
                        kill_q <= 1'b1;
                    end
                    if (dmem_resp) begin
                        dmemRead_q  <= 1'b0;
                        dmemWrite_q <= 1'b0;
                        if (isLoad_q) begin
                            data_q  <= alignedData;
                            state_q <= WB;
                        end else begin
                            pendingValid_q <= 1'b0;
                            pendingRd_q    <= 5'd0;
                            state_q        <= IDLE;
                        end
                    end
                end
                WB: begin
                    if (wawHit) begin
                        kill_q <= 1'b1;
                    end
                    // Pending info stays up through this last WB cycle.
                    if (rfWrFire || kill_q || (rd_q == 5'd0)) begin
                        pendingValid_q <= 1'b0;
                        pendingRd_q    <= 5'd0;
                        state_q        <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign capture_ready    = (state_q == IDLE);
    assign dmem_read        = dmemRead_q;
    assign dmem_write       = dmemWrite_q;
    assign dmem_address     = {addr_q[31:2], 2'b00};
    assign dmem_wdata       = wdata_q;
    assign dmem_byte_enable = isLoad_q ? 4'hF : wmask_q;
    assign rf_wr            = rfWrFire;
    assign rf_rd            = rd_q;
    assign rf_data          = data_q;
    assign pending_valid    = pendingValid_q;
    assign pending_rd       = pendingRd_q;

    // Only one op can be held; the MA stage must stall while we are busy.
    captureProtocol: assert property (@(posedge clk) disable iff (rst)
        capture_valid |-> capture_ready);

endmodule

// File: tb/tb_leap_retire.sv
// tb_leap_retire
//   Directed self-checking bench for leap_retire. Drives hand-offs, dcache
//   responses and pipeline writeback traffic, and checks outputs against
//   hand-computed values.
module tb_leap_retire;

    logic        clk;
    logic        rst;
    logic        capture_valid;
    logic        capture_ready;
    logic        capture_is_load;
    logic [2:0]  capture_funct3;
    logic [4:0]  capture_rd;
    logic [31:0] capture_addr;
    logic [31:0] capture_wdata;
    logic [3:0]  capture_wmask;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        wb_pipe_valid;
    logic [4:0]  wb_pipe_rd;
    logic        rf_wr;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic        pending_valid;
    logic [4:0]  pending_rd;

    int compared;
    int mismatched;

    leap_retire dut (
        .clk              (clk),
        .rst              (rst),
        .capture_valid    (capture_valid),
        .capture_ready    (capture_ready),
        .capture_is_load  (capture_is_load),
        .capture_funct3   (capture_funct3),
        .capture_rd       (capture_rd),
        .capture_addr     (capture_addr),
        .capture_wdata    (capture_wdata),
        .capture_wmask    (capture_wmask),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_rdata       (dmem_rdata),
        .dmem_resp        (dmem_resp),
        .wb_pipe_valid    (wb_pipe_valid),
        .wb_pipe_rd       (wb_pipe_rd),
        .rf_wr            (rf_wr),
        .rf_rd            (rf_rd),
        .rf_data          (rf_data),
        .pending_valid    (pending_valid),
        .pending_rd       (pending_rd)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs set here are sampled
    // on the following edge and outputs reflect the new register state.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One comparison: count it, and on a miss count and report it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Present one hand-off for a single cycle, then settle in cycle t+1.
    task automatic applyStimulus(input logic isLoad, input logic [2:0] funct3,
                                 input logic [4:0] rd, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wmask);
        capture_valid   = 1'b1;
        capture_is_load = isLoad;
        capture_funct3  = funct3;
        capture_rd      = rd;
        capture_addr    = addr;
        capture_wdata   = wdata;
        capture_wmask   = wmask;
        tick();
        capture_valid   = 1'b0;
        #1;
    endtask

    // Return a dcache response sampled at edge r; leaves us settled in r+1.
    task automatic respond(input logic [31:0] rdata);
        dmem_resp  = 1'b1;
        dmem_rdata = rdata;
        tick();
        dmem_resp  = 1'b0;
        dmem_rdata = 32'd0;
        #1;
    endtask

    // Hard time limit so the bench never hangs.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] time limit reached");
    end

    // Directed sequence of scenarios, each with hand-computed expectations.
    initial begin
        compared        = 0;
        mismatched      = 0;
        rst             = 1'b1;
        capture_valid   = 1'b0;
        capture_is_load = 1'b0;
        capture_funct3  = 3'd0;
        capture_rd      = 5'd0;
        capture_addr    = 32'd0;
        capture_wdata   = 32'd0;
        capture_wmask   = 4'd0;
        dmem_rdata      = 32'd0;
        dmem_resp       = 1'b0;
        wb_pipe_valid   = 1'b0;
        wb_pipe_rd      = 5'd0;

        // Reset state.
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("reset capture_ready", capture_ready, 1);
        checkOutput("reset dmem_read", dmem_read, 0);
        checkOutput("reset dmem_write", dmem_write, 0);
        checkOutput("reset byte_enable", dmem_byte_enable, 0);
        checkOutput("reset address", dmem_address, 0);
        checkOutput("reset rf_wr", rf_wr, 0);
        checkOutput("reset rf_data", rf_data, 0);
        checkOutput("reset pending_valid", pending_valid, 0);
        checkOutput("reset pending_rd", pending_rd, 0);

        // lw miss at 0x1000_0008, rd 5, response after 10 request cycles.
        applyStimulus(1'b1, 3'b010, 5'd5, 32'h1000_0008, 32'h0, 4'h0);
        checkOutput("lw dmem_read", dmem_read, 1);
        checkOutput("lw dmem_write", dmem_write, 0);
        checkOutput("lw address", dmem_address, 32'h1000_0008);
        checkOutput("lw byte_enable", dmem_byte_enable, 4'hF);
        checkOutput("lw capture_ready", capture_ready, 0);
        checkOutput("lw pending_valid", pending_valid, 1);
        for (int i = 0; i < 9; i++) begin
            tick();
            checkOutput("lw hold dmem_read", dmem_read, 1);
            checkOutput("lw hold pending_rd", pending_rd, 5);
        end
        respond(32'hDEAD_BEEF);
        checkOutput("lw rf_wr", rf_wr, 1);
        checkOutput("lw rf_rd", rf_rd, 5);
        checkOutput("lw rf_data", rf_data, 32'hDEAD_BEEF);
        checkOutput("lw wb pending_rd", pending_rd, 5);
        checkOutput("lw wb dmem_read", dmem_read, 0);
        tick();
        checkOutput("lw done capture_ready", capture_ready, 1);
        checkOutput("lw done pending_valid", pending_valid, 0);
        checkOutput("lw done rf_wr", rf_wr, 0);

        // lb at offset 3: byte 0x80 sign-extends.
        applyStimulus(1'b1, 3'b000, 5'd6, 32'h0000_2003, 32'h0, 4'h0);
        checkOutput("lb address", dmem_address, 32'h0000_2000);
        respond(32'h80FF_FFFF);
        checkOutput("lb rf_wr", rf_wr, 1);
        checkOutput("lb rf_data", rf_data, 32'hFFFF_FF80);
        tick();

        // lhu at offset 2: upper half zero-extends.
        applyStimulus(1'b1, 3'b101, 5'd9, 32'h0000_3002, 32'h0, 4'h0);
        respond(32'h8001_0000);
        checkOutput("lhu rf_rd", rf_rd, 9);
        checkOutput("lhu rf_data", rf_data, 32'h0000_8001);
        tick();

        // lbu at offset 1: byte 0x9A zero-extends.
        applyStimulus(1'b1, 3'b100, 5'd4, 32'h0000_3101, 32'h0, 4'h0);
        respond(32'h0000_9A00);
        checkOutput("lbu rf_data", rf_data, 32'h0000_009A);
        tick();

        // Store: strobes and payload stable until resp, no register write.
        applyStimulus(1'b0, 3'b000, 5'd3, 32'h0000_4006, 32'hAABB_0000, 4'b1100);
        checkOutput("st pending_rd", pending_rd, 0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("st dmem_write", dmem_write, 1);
            checkOutput("st dmem_read", dmem_read, 0);
            checkOutput("st address", dmem_address, 32'h0000_4004);
            checkOutput("st wdata", dmem_wdata, 32'hAABB_0000);
            checkOutput("st byte_enable", dmem_byte_enable, 4'b1100);
            tick();
        end
        respond(32'h0);
        checkOutput("st done dmem_write", dmem_write, 0);
        checkOutput("st done rf_wr", rf_wr, 0);
        checkOutput("st done capture_ready", capture_ready, 1);

        // Port conflict: pipeline owns the port for 3 cycles after resp.
        applyStimulus(1'b1, 3'b010, 5'd10, 32'h0000_5000, 32'h0, 4'h0);
        dmem_resp     = 1'b1;
        dmem_rdata    = 32'h1357_9BDF;
        tick();
        dmem_resp     = 1'b0;
        wb_pipe_valid = 1'b1;
        wb_pipe_rd    = 5'd11;
        #1;
        checkOutput("conflict r+1 rf_wr", rf_wr, 0);
        tick();
        checkOutput("conflict r+2 rf_wr", rf_wr, 0);
        tick();
        checkOutput("conflict r+3 rf_wr", rf_wr, 0);
        checkOutput("conflict r+3 pending_rd", pending_rd, 10);
        tick();
        wb_pipe_valid = 1'b0;
        #1;
        checkOutput("conflict r+4 rf_wr", rf_wr, 1);
        checkOutput("conflict r+4 rf_rd", rf_rd, 10);
        checkOutput("conflict r+4 rf_data", rf_data, 32'h1357_9BDF);
        tick();
        checkOutput("conflict done capture_ready", capture_ready, 1);

        // WAW kill during REQ: pipeline writes rd 7 while we hold rd 7.
        applyStimulus(1'b1, 3'b010, 5'd7, 32'h0000_6000, 32'h0, 4'h0);
        wb_pipe_valid = 1'b1;
        wb_pipe_rd    = 5'd7;
        tick();
        wb_pipe_valid = 1'b0;
        #1;
        respond(32'h1234_5678);
        checkOutput("kill req rf_wr", rf_wr, 0);
        tick();
        checkOutput("kill req capture_ready", capture_ready, 1);
        checkOutput("kill req rf_wr after", rf_wr, 0);

        // rd 0 load with a pipeline write to x0: no write, no kill.
        applyStimulus(1'b1, 3'b010, 5'd0, 32'h0000_7000, 32'h0, 4'h0);
        checkOutput("rd0 pending_rd", pending_rd, 0);
        wb_pipe_valid = 1'b1;
        wb_pipe_rd    = 5'd0;
        tick();
        wb_pipe_valid = 1'b0;
        #1;
        respond(32'hCAFE_F00D);
        checkOutput("rd0 rf_wr", rf_wr, 0);
        tick();
        checkOutput("rd0 capture_ready", capture_ready, 1);

        // WAW kill during WB: the pipeline write lands in r+1.
        applyStimulus(1'b1, 3'b010, 5'd14, 32'h0000_7100, 32'h0, 4'h0);
        respond(32'h0BAD_0BAD);
        wb_pipe_valid = 1'b1;
        wb_pipe_rd    = 5'd14;
        #1;
        checkOutput("kill wb r+1 rf_wr", rf_wr, 0);
        tick();
        wb_pipe_valid = 1'b0;
        #1;
        checkOutput("kill wb r+2 rf_wr", rf_wr, 0);
        tick();
        checkOutput("kill wb capture_ready", capture_ready, 1);

        // Reset in the middle of REQ abandons the request.
        applyStimulus(1'b1, 3'b010, 5'd12, 32'h0000_8000, 32'h0, 4'h0);
        checkOutput("rstreq dmem_read", dmem_read, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checkOutput("rstreq dmem_read after", dmem_read, 0);
        checkOutput("rstreq dmem_write after", dmem_write, 0);
        checkOutput("rstreq pending_valid", pending_valid, 0);
        checkOutput("rstreq capture_ready", capture_ready, 1);

        // A fresh lh at offset 0 then completes normally.
        applyStimulus(1'b1, 3'b001, 5'd13, 32'h0000_9000, 32'h0, 4'h0);
        checkOutput("post rst dmem_read", dmem_read, 1);
        respond(32'h1234_8765);
        checkOutput("post rst rf_wr", rf_wr, 1);
        checkOutput("post rst rf_rd", rf_rd, 13);
        checkOutput("post rst rf_data", rf_data, 32'hFFFF_8765);
        tick();
        checkOutput("post rst capture_ready", capture_ready, 1);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
